// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response bus plus the decode-side instruction handshake.
interface fetch_unit_if #(parameter int ADDR_W = 64, parameter int INST_W = 32);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with in-order response FIFO, redirect/flush and draining halt.
// Defining FETCH_PERF_CNT_EN adds the perf_fetched / perf_dropped saturating counters.
module fetch_unit #(
  parameter int              ADDR_W  = 64,
  parameter int              INST_W  = 32,
  parameter int              DEPTH   = 4,
  parameter logic [ADDR_W-1:0] INIT_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, wr_q, wr_d, rd_q, rd_d, cnt;
  logic halt_pend_q, halt_pend_d;
  logic [ADDR_W+INST_W-1:0] mem_q [DEPTH];
  logic [CW+1:0] used;
  logic redir, hs, rsp_drop, push, pop;
  always_comb begin
    cnt = wr_q - rd_q;
    used = (CW+2)'(cnt) + (CW+2)'(out_q) + (CW+2)'(drop_q);
    redir = redirect_valid && state_q != HALTED;
    bus.imem_req_valid = !reset && state_q == RUN && !freeze && !redirect_valid && used < (CW+2)'(DEPTH);
    bus.imem_req_addr = pc_q;
    hs = bus.imem_req_valid && bus.imem_req_ready;
    rsp_drop = bus.imem_rsp_valid && (redir || drop_q != '0);
    push = bus.imem_rsp_valid && !rsp_drop;
    bus.inst_valid = cnt != '0;
    {bus.inst_pc, bus.inst_data} = mem_q[rd_q[AW-1:0]];
    pop = bus.inst_valid && bus.inst_ready && !redir;
    pc_d = redir ? redirect_pc : hs ? pc_q + STEP : pc_q;
    rsp_pc_d = redir ? redirect_pc : push ? rsp_pc_q + STEP : rsp_pc_q;
    out_d = redir ? '0 : out_q + CW'(hs) - CW'(push);
    // a same-cycle response consumes one in-flight slot whether it was already wrong-path or not
    drop_d = redir ? drop_q + out_q - CW'(bus.imem_rsp_valid) : drop_q - CW'(rsp_drop);
    wr_d = wr_q + CW'(push);
    rd_d = redir ? wr_q : rd_q + CW'(pop);
    halt_pend_d = halt_pend_q | halt_req;
    state_d = (state_q == RUN && halt_pend_d && !freeze) ? DRAIN :
              (state_q == DRAIN && out_q == '0 && drop_q == '0) ? HALTED : state_q;
    pc = pc_q;
    halted = state_q == HALTED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      pc_q <= INIT_PC;
      rsp_pc_q <= INIT_PC;
      out_q <= '0;
      drop_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      halt_pend_q <= halt_pend_d;
    end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {rsp_pc_q, bus.imem_rsp_data};
    assert (reset || !push || pop || cnt != CW'(DEPTH));
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_q, pf_d, pd_q, pd_d;
  logic [32:0] pd_sum;
  always_comb begin
    pd_sum = {1'b0, pd_q} + 33'(rsp_drop) + (redir ? 33'(cnt) : 33'd0);
    pf_d = (state_q == HALTED || !pop || &pf_q) ? pf_q : pf_q + 32'd1;
    pd_d = state_q == HALTED ? pd_q : pd_sum[32] ? '1 : pd_sum[31:0];
    perf_fetched = pf_q;
    perf_dropped = pd_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pf_q <= '0;
      pd_q <= '0;
    end else begin
      pf_q <= pf_d;
      pd_q <= pd_d;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed stimulus against an in-flight/FIFO queue model of the fetch unit.
module tb_fetch_unit;
  localparam int AW = 64, IW = 32, D = 4;
  localparam logic [63:0] INIT = 64'h1000;
  logic clk = 1'b0;
  logic reset, freeze, halt_req, redirect_valid, halted;
  logic [63:0] redirect_pc, pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();
  fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .INIT_PC(INIT)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(bus),
    .pc(pc), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );
  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int due; bit wrong; } fl_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; } fe_t;
  fl_t infl[$];
  fe_t fifo[$];
  logic [63:0] req_log[$], pop_log[$];
  logic [63:0] m_pc, f_pc, saved_pc;
  bit m_drain, m_halted, m_pend, f_redir, f_halt, redir_on_rsp, fired;
  int p_ready, lat_lo, lat_hi, p_iready, p_redir, p_freeze;
  int cyc, last_due, n_chk, n_err, m_fetched, m_dropped, n_before;

  function automatic logic [31:0] imem_data(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [63:0] at(input logic [63:0] q[$], input int i);
    return i < q.size() ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] rand_pc();
    return $urandom_range(3) == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom} & ~64'h3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // entered and left at a falling edge; the rising edge happens inside
  task automatic cycle();
    bit exp_rv, redir, pop, hs;
    int n0, due;
    fl_t e;
    bus.imem_req_ready = $urandom_range(99) < p_ready;
    bus.inst_ready = $urandom_range(99) < p_iready;
    freeze = $urandom_range(99) < p_freeze;
    halt_req = f_halt;
    bus.imem_rsp_valid = infl.size() > 0 && infl[0].due <= cyc;
    bus.imem_rsp_data = infl.size() > 0 ? imem_data(infl[0].addr) : 32'h0;
    redirect_valid = f_redir || (redir_on_rsp && bus.imem_rsp_valid) || $urandom_range(99) < p_redir;
    redirect_pc = (f_redir || redir_on_rsp) ? f_pc : rand_pc();
    if (redir_on_rsp && bus.imem_rsp_valid) fired = 1;
    #1;
    exp_rv = !m_drain && !m_halted && !freeze && !redirect_valid && fifo.size() + infl.size() < D;
    chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("inst_valid", 64'(bus.inst_valid), 64'(fifo.size() > 0));
    if (fifo.size() > 0) begin
      chk("inst_pc", bus.inst_pc, fifo[0].pc);
      chk("inst_data", 64'(bus.inst_data), 64'(fifo[0].data));
    end
    chk("pc", pc, m_pc);
    chk("halted", 64'(halted), 64'(m_halted));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    chk("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
`endif
    n0 = infl.size();
    redir = redirect_valid && !m_halted;
    hs = exp_rv && bus.imem_req_ready;
    pop = fifo.size() > 0 && bus.inst_ready && !redir;
    if (pop) begin
      pop_log.push_back(fifo[0].pc);
      void'(fifo.pop_front());
      if (!m_halted) m_fetched++;
    end
    if (bus.imem_rsp_valid) begin
      e = infl.pop_front();
      if (!e.wrong && !redir) fifo.push_back('{e.addr, imem_data(e.addr)});
      else m_dropped++;
    end
    if (redir) begin
      m_dropped += fifo.size();
      fifo.delete();
      foreach (infl[i]) infl[i].wrong = 1;
      m_pc = redirect_pc;
    end
    if (hs) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      infl.push_back('{m_pc, due, 1'b0});
      req_log.push_back(m_pc);
      m_pc += 64'd4;
    end
    if (!m_halted) begin
      if (m_drain) begin
        if (n0 == 0) begin m_halted = 1; m_drain = 0; end
      end else begin
        m_pend |= halt_req;
        if (m_pend && !freeze) m_drain = 1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int dly);
    #(dly);
    reset = 1;
    bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0; bus.imem_req_ready = 0; bus.inst_ready = 0;
    redirect_valid = 0; redirect_pc = '0; freeze = 0; halt_req = 0;
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_pc", pc, INIT);
    chk("rst_halted", 64'(halted), 64'd0);
    infl.delete(); fifo.delete(); req_log.delete(); pop_log.delete();
    m_pc = INIT; m_drain = 0; m_halted = 0; m_pend = 0; m_fetched = 0; m_dropped = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0; cyc = 0; last_due = 0;
  endtask

  task automatic set_knobs(input int r, input int lo, input int hi, input int ir, input int rd, input int fz);
    p_ready = r; lat_lo = lo; lat_hi = hi; p_iready = ir; p_redir = rd; p_freeze = fz;
  endtask

  initial begin
    n_chk = 0; n_err = 0; f_redir = 0; f_halt = 0; redir_on_rsp = 0; fired = 0; f_pc = '0;
    set_knobs(100, 2, 2, 100, 0, 0);
    do_reset(0);
    // streaming at one instruction per cycle
    repeat (10) cycle();
    chk("req0", at(req_log, 0), 64'h1000);
    chk("req1", at(req_log, 1), 64'h1004);
    chk("req2", at(req_log, 2), 64'h1008);
    pop_log.delete();
    repeat (10) cycle();
    chk("sustained_pops", 64'(pop_log.size()), 64'd10);
    // consumer stall fills the FIFO and stops requests
    req_log.delete(); pop_log.delete();
    p_iready = 0;
    repeat (10) cycle();
    chk("stall_req_bound", 64'(req_log.size() <= D), 64'd1);
    chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    p_iready = 100;
    repeat (8) cycle();
    for (int i = 0; i < 3; i++) chk("stall_pop_order", at(pop_log, i + 1), at(pop_log, i) + 64'd4);
    // redirect with requests in flight
    set_knobs(100, 3, 3, 100, 0, 0);
    repeat (10) cycle();
    n_before = infl.size();
    f_redir = 1; f_pc = 64'h2000;
    cycle();
    f_redir = 0;
    chk("redir_inflight", 64'(n_before > 0), 64'd1);
    req_log.delete(); pop_log.delete();
    repeat (12) cycle();
    chk("redir_req0", at(req_log, 0), 64'h2000);
    chk("redir_pop0", at(pop_log, 0), 64'h2000);
    // redirect coinciding with a response
    f_pc = 64'h3000; redir_on_rsp = 1; fired = 0;
    for (int i = 0; i < 20 && !fired; i++) cycle();
    redir_on_rsp = 0;
    chk("rsp_redir_fired", 64'(fired), 64'd1);
    req_log.delete(); pop_log.delete();
    repeat (12) cycle();
    chk("rsp_redir_pop0", at(pop_log, 0), 64'h3000);
    // random traffic with redirects and freezes
    set_knobs(70, 1, 4, 60, 4, 8);
    repeat (600) cycle();
    // draining halt
    set_knobs(100, 2, 2, 50, 0, 0);
    repeat (6) cycle();
    f_halt = 1;
    cycle();
    f_halt = 0;
    for (int i = 0; i < 60 && !halted; i++) cycle();
    chk("halt_reached", 64'(halted), 64'd1);
    saved_pc = pc;
    f_redir = 1; f_pc = 64'h5000;
    cycle();
    f_redir = 0;
    p_iready = 100;
    repeat (6) cycle();
    chk("halt_pc_frozen", pc, saved_pc);
    chk("halt_no_req", 64'(bus.imem_req_valid), 64'd0);
    chk("halt_fifo_drained", 64'(bus.inst_valid), 64'd0);
    // address wrap, then reset mid-burst
    do_reset(0);
    f_redir = 1; f_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    cycle();
    f_redir = 0;
    req_log.delete();
    repeat (6) cycle();
    chk("wrap_req0", at(req_log, 0), 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_req1", at(req_log, 1), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req2", at(req_log, 2), 64'h0);
    do_reset(3);
    repeat (5) cycle();
    chk("post_reset_req0", at(req_log, 0), INIT);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
